// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request at a time, 2-entry in-order
// queue of {instr, pc+4} feeding IF/ID, flushed on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        IF_ID_Write,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] PC_plus_four_out,
  output logic        fetch_valid
);

  localparam logic [1:0] DEPTH_C = 2'(BUF_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    REQ_DROP,
    DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] issued_pc_q, issued_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hd_instr_q, hd_instr_d, hd_pc4_q, hd_pc4_d;
  logic [31:0] tl_instr_q, tl_instr_d, tl_pc4_q, tl_pc4_d;
  logic [1:0]  count_q, count_d, count_pop;
  logic        pop, push;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  assign fetch_valid      = (count_q != 2'd0);
  assign instr_out        = fetch_valid ? hd_instr_q : '1;
  assign PC_plus_four_out = fetch_valid ? hd_pc4_q : '0;
  assign imem_req         = (state_q == REQ) || (state_q == REQ_DROP);
  assign imem_addr        = req_addr_q;
  assign pop              = IF_ID_Write & fetch_valid;
  assign count_pop        = count_q - {1'b0, pop};

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    req_addr_d  = req_addr_q;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect && (count_pop < DEPTH_C)) state_d = REQ;
      end
      REQ: begin
        if (imem_ready) begin
          issued_pc_d = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + 32'd4;
          state_d     = redirect ? DROP : WAIT;
        end else if (redirect) begin
          state_d = REQ_DROP;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect) begin
            state_d = IDLE;
          end else begin
            push    = 1'b1;
            state_d = ((count_pop + 2'd1) < DEPTH_C) ? REQ : IDLE;
          end
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      REQ_DROP: begin
        if (imem_ready) state_d = DROP;
      end
      DROP: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect) fetch_pc_d = {redirect_pc[31:2], 2'b00};
    // The request address is frozen while req is held, so a redirect in REQ
    // retargets fetch_pc without disturbing the request already on the bus.
    if ((state_q != REQ) && (state_q != REQ_DROP)) req_addr_d = fetch_pc_d;
  end

  always_comb begin
    hd_instr_d = hd_instr_q;
    hd_pc4_d   = hd_pc4_q;
    tl_instr_d = tl_instr_q;
    tl_pc4_d   = tl_pc4_q;
    count_d    = count_q;
    if (redirect) begin
      count_d = '0;
    end else begin
      if (pop) begin
        hd_instr_d = tl_instr_q;
        hd_pc4_d   = tl_pc4_q;
      end
      if (push) begin
        if (count_pop == 2'd0) begin
          hd_instr_d = imem_rdata;
          hd_pc4_d   = issued_pc_q + 32'd4;
        end else begin
          tl_instr_d = imem_rdata;
          tl_pc4_d   = issued_pc_q + 32'd4;
        end
      end
      count_d = count_pop + {1'b0, push};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= RESET_PC;
      req_addr_q  <= RESET_PC;
      hd_instr_q  <= '1;
      hd_pc4_q    <= '0;
      tl_instr_q  <= '1;
      tl_pc4_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      req_addr_q  <= req_addr_d;
      hd_instr_q  <= hd_instr_d;
      hd_pc4_q    <= hd_pc4_d;
      tl_instr_q  <= tl_instr_d;
      tl_pc4_q    <= tl_pc4_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + short random bench for fetch_unit: behavioural imem with configurable
// latency, scoreboard of expected {instr, pc+4} queued on each fresh response.
module tb_fetch_unit;

  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        IF_ID_Write;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] PC_plus_four_out;
  logic        fetch_valid;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .IF_ID_Write     (IF_ID_Write),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .instr_out       (instr_out),
    .PC_plus_four_out(PC_plus_four_out),
    .fetch_valid     (fetch_valid)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int          lat = 1;
  bit          rnd_mode = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  bit          pend_stale = 1'b0;
  bit          req_stale = 1'b0;
  logic [31:0] exp_pc = '0;
  int          n_valid;
  int          n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the scoreboard, advance the model.
  task automatic cycle(input bit wr, input bit redir, input logic [31:0] rpc);
    bit acc;
    IF_ID_Write = wr;
    redirect    = redir;
    redirect_pc = rpc;
    imem_ready  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pend_cnt == 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_addr ^ MAGIC;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    if (sbq.size() > 0) begin
      chk("head_valid", 32'(fetch_valid), 32'd1);
      chk("head_instr", instr_out, sbq[0].instr);
      chk("head_pc4", PC_plus_four_out, sbq[0].pc4);
    end else begin
      chk("empty_valid", 32'(fetch_valid), 32'd0);
      chk("bubble_instr", instr_out, 32'hFFFF_FFFF);
      chk("bubble_pc4", PC_plus_four_out, 32'd0);
    end
    if (imem_req && !req_stale) chk("req_addr", imem_addr, exp_pc);
    acc = imem_req && imem_ready;
    if (wr && sbq.size() > 0) void'(sbq.pop_front());
    if (pend_cnt == 1) begin
      if (!pend_stale && !redir) sbq.push_back('{instr: pend_addr ^ MAGIC, pc4: pend_addr + 32'd4});
      pend_cnt = 0;
    end else if (pend_cnt > 1) begin
      pend_cnt--;
    end
    if (acc) begin
      pend_addr  = imem_addr;
      pend_stale = req_stale | redir;
      pend_cnt   = rnd_mode ? int'($urandom_range(1, 3)) : lat;
      req_stale  = 1'b0;
      if (!pend_stale) exp_pc = exp_pc + 32'd4;
    end else if (redir && imem_req) begin
      req_stale = 1'b1;
    end
    if (redir) begin
      sbq.delete();
      pend_stale = 1'b1;
      exp_pc     = {rpc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_instr"}, instr_out, 32'hFFFF_FFFF);
    chk({tag, "_pc4"}, PC_plus_four_out, 32'd0);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(fetch_valid), 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
  endtask

  // Called just after a posedge; the memory model is reset together with the core.
  task automatic do_reset(input bit force_rv);
    rst = 1'b0;
    #1;
    reset_checks("rst_async");
    repeat (2) begin
      IF_ID_Write = 1'($urandom_range(0, 1));
      redirect    = 1'($urandom_range(0, 1));
      redirect_pc = $urandom;
      imem_ready  = 1'($urandom_range(0, 1));
      imem_rvalid = force_rv ? 1'b1 : 1'($urandom_range(0, 1));
      imem_rdata  = force_rv ? 32'hDEAD_BEEF : $urandom;
      @(posedge clk);
      #1;
    end
    reset_checks("rst_held");
    IF_ID_Write = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    sbq.delete();
    pend_cnt   = 0;
    pend_stale = 1'b0;
    req_stale  = 1'b0;
    exp_pc     = 32'h0000_0000;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    n = 0;
    while (fetch_valid !== 1'b1 && n < 30) begin
      cycle(1'b1, 1'b0, '0);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 30), 32'd1);
  endtask

  initial begin
    rst         = 1'b0;
    IF_ID_Write = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    @(posedge clk);
    #1;

    // Zero-wait stream: first word visible two cycles after the first request, then every 2nd cycle.
    lat = 1;
    do_reset(1'b0);
    n_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (fetch_valid === 1'b1) n_valid++;
      cycle(1'b1, 1'b0, '0);
    end
    chk("stream_rate", 32'(n_valid), 32'd9);

    // Stall: two words buffered, fetch stops, then drains in order and resumes at 8.
    do_reset(1'b0);
    repeat (8) cycle(1'b0, 1'b0, '0);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_valid", 32'(fetch_valid), 32'd1);
    chk("stall_head_pc4", PC_plus_four_out, 32'd4);
    chk("stall_head_instr", instr_out, MAGIC);
    cycle(1'b1, 1'b0, '0);
    chk("drain_second_pc4", PC_plus_four_out, 32'd8);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'd8);
    repeat (6) cycle(1'b1, 1'b0, '0);

    // Redirect while WAIT with 3-cycle latency; unaligned target is truncated.
    lat = 3;
    do_reset(1'b0);
    cycle(1'b1, 1'b0, '0);
    chk("lat_in_wait_req", 32'(imem_req), 32'd0);
    cycle(1'b1, 1'b1, 32'h0000_0102);
    chk("redir_bubble", 32'(fetch_valid), 32'd0);
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      cycle(1'b1, 1'b0, '0);
      n++;
    end
    chk("redir_req_timeout", 32'(n < 20), 32'd1);
    chk("redir_req_addr", imem_addr, 32'h0000_0100);
    wait_valid("redir_valid");
    chk("redir_first_pc4", PC_plus_four_out, 32'h0000_0104);
    chk("redir_first_instr", instr_out, 32'h0000_0100 ^ MAGIC);

    // Redirect coincident with rvalid while one entry is queued.
    lat = 1;
    do_reset(1'b0);
    repeat (3) cycle(1'b0, 1'b0, '0);
    chk("coinc_valid_before", 32'(fetch_valid), 32'd1);
    chk("coinc_wait_req", 32'(imem_req), 32'd0);
    cycle(1'b1, 1'b1, 32'h0000_0200);
    chk("coinc_valid_after", 32'(fetch_valid), 32'd0);
    chk("coinc_instr_after", instr_out, 32'hFFFF_FFFF);
    chk("coinc_pc4_after", PC_plus_four_out, 32'd0);
    wait_valid("coinc_valid");
    chk("coinc_first_pc4", PC_plus_four_out, 32'h0000_0204);

    // Address wrap at the top of memory.
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    wait_valid("wrap_valid");
    chk("wrap_pc4", PC_plus_four_out, 32'd0);
    chk("wrap_instr", instr_out, 32'hFFFF_FFFC ^ MAGIC);
    cycle(1'b1, 1'b0, '0);
    wait_valid("wrap_next_valid");
    chk("wrap_next_pc4", PC_plus_four_out, 32'd4);

    // Async reset mid-WAIT with rvalid arriving during reset.
    lat = 3;
    do_reset(1'b0);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    do_reset(1'b1);
    cycle(1'b1, 1'b0, '0);
    chk("mid_rst_valid", 32'(fetch_valid), 32'd0);
    wait_valid("mid_rst_fetch");
    chk("mid_rst_pc4", PC_plus_four_out, 32'd4);
    chk("mid_rst_instr", instr_out, MAGIC);

    // Random ready, latency, stalls and redirects.
    do_reset(1'b0);
    rnd_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), $urandom);
    end
    rnd_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
